memory: RTL and testbench
=========================

MEMORY -- requirements
Module: memory

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising edge; reset  in  1  asynchronous, active-high.
REQ-002 SHALL have dataE  in  execute_data_t  producer fields: pc 64, result_alu 64 (address/ALU result), wd 64 (store data), wa 5, ctl.regwrite, ctl.memread, ctl.memwrite, ctl.msize 2 (0=B,1=H,2=W,3=D), ctl.mem_unsigned.
REQ-003 SHALL have dataM  out  memory_data_t  fields: pc 64, ctl, result 64, wa 5.
REQ-004 SHALL have forwardM  out  forward_data_t  fields: wa 5, result 64, regwrite 1.
REQ-005 SHALL have stallM  out  1  holds upstream pipeline register while high.
REQ-006 SHALL have misalignM  out  1  misaligned access flagged.
REQ-007 SHALL have dreq  out  dbus_req_t  fields: valid 1, addr 64, size 3, strobe 8, data 64.
REQ-008 SHALL have dresp  in  dbus_resp_t  fields: addr_ok 1, data_ok 1, data 64.

Function
REQ-009 FSM states SHALL be IDLE, WAIT and DONE.
REQ-010 A memory op SHALL be ctl.memread | ctl.memwrite, with misalignment = addr bits not aligned to 2^msize.
REQ-011 IDLE, with an aligned memory op: dreq.valid=1, stallM=1, next state WAIT.
REQ-012 IDLE, with no op or a misaligned op: dreq.valid=0, stallM=0, state stays IDLE.
REQ-013 WAIT: dreq.valid=1 and stallM=1; on dresp.data_ok the FSM SHALL capture dresp.data into a 64-bit register and go to DONE.
REQ-014 DONE: dreq.valid=0 and stallM=0 for exactly one cycle, then IDLE.
REQ-015 Memory-op latency: minimum 3 cycles (IDLE, WAIT, DONE), with WAIT extended until data_ok.
REQ-016 While dreq.valid=1, addr, size, strobe and data SHALL stay stable; addr_ok is ignored; data_ok counts only in WAIT.
REQ-017 Bus fields: dreq.addr = result_alu; dreq.size = {1'b0, msize}.
REQ-018 Loads SHALL drive strobe = 0.
REQ-019 Stores SHALL drive strobe = ((1<<2^msize)-1) << addr[2:0] and data = wd << (8*addr[2:0]).
REQ-020 Load result SHALL be the captured data >> (8*addr[2:0]), truncated to 2^msize bytes, then zero-extended if mem_unsigned, else sign-extended.
REQ-021 dataM.result SHALL be the extended load data in DONE for loads, result_alu otherwise (stores, ALU ops and misaligned ops).
REQ-022 dataM.pc, dataM.ctl and dataM.wa SHALL pass through from dataE unchanged.
REQ-023 misalignM SHALL be 1 combinationally in IDLE for a misaligned op; no bus access is made and dataM.result = 0.
REQ-024 forwardM SHALL carry wa = dataM.wa, result = dataM.result, and regwrite = dataM.ctl.regwrite & ~stallM.
REQ-025 dataE SHALL be stable while stallM=1; the block does not re-sample it until DONE.
REQ-026 data_ok arriving in the same cycle the request is first raised (IDLE) SHALL be ignored; capture happens only in WAIT.

Reset
REQ-027 reset SHALL force state IDLE and clear the capture register to 0, asynchronously.
REQ-028 During reset: dreq.valid=0, stallM=0, misalignM=0; dataM and forwardM keep following dataE combinationally.
REQ-029 Reset during WAIT SHALL abandon the transaction; a data_ok arriving after reset releases is ignored while in IDLE.

Verification
REQ-030 Load-byte signed: addr=0x...03, msize=0, mem_unsigned=0, data_ok after 2 WAIT cycles with data=0x0000_0000_8000_0000 -> stallM high for 3 cycles, DONE result=0xFFFF_FFFF_FFFF_FF80 (byte 3 = 0x80).
REQ-031 Store half: addr=0x...06, wd=0xBEEF -> strobe=0xC0, data=0xBEEF_0000_0000_0000, valid held until data_ok, forwardM.regwrite=0 throughout.
REQ-032 Misaligned word: addr=0x...02, msize=2 -> misalignM=1, dreq.valid=0, stallM=0, result=0, all in the same cycle.
REQ-033 ALU op: memread=memwrite=0, result_alu=0x1234, regwrite=1 -> no stall, forwardM.result=0x1234, forwardM.regwrite=1.
REQ-034 Reset asserted in WAIT -> dreq.valid=0 immediately; data_ok one cycle after release leaves the FSM in IDLE and the register at 0.
REQ-035 Load double with data_ok in the IDLE cycle -> ignored; a second data_ok in WAIT is captured, result = full 64-bit word.

Source files
------------

// File: rtl/memory.sv
`timescale 1ns/1ps
// Memory pipeline stage: issues one data-bus request per load/store, stalls until data_ok,
// then aligns and sign/zero-extends load data. Struct-like ports are packed vectors.
module memory (
    input  logic         clk,
    input  logic         reset,
    // dataE = {pc[64], result_alu[64], wd[64], wa[5], ctl[6]}
    // ctl   = {regwrite, memread, memwrite, msize[2], mem_unsigned}
    input  logic [202:0] dataE,
    // dataM = {pc[64], ctl[6], result[64], wa[5]}
    output logic [138:0] dataM,
    // forwardM = {wa[5], result[64], regwrite}
    output logic [69:0]  forwardM,
    output logic         stallM,
    output logic         misalignM,
    // dreq = {valid, addr[64], size[3], strobe[8], data[64]}
    output logic [139:0] dreq,
    // dresp = {addr_ok, data_ok, data[64]}
    input  logic [65:0]  dresp
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [63:0] rdata_q, rdata_d;

    logic [63:0] pc, result_alu, wd;
    logic [4:0]  wa;
    logic [5:0]  ctl;
    logic        regwrite, memread, memwrite, mem_unsigned;
    logic [1:0]  msize;
    logic        data_ok;
    logic [63:0] resp_data;
    logic        unused_addr_ok;

    assign pc             = dataE[202:139];
    assign result_alu     = dataE[138:75];
    assign wd             = dataE[74:11];
    assign wa             = dataE[10:6];
    assign ctl            = dataE[5:0];
    assign regwrite       = ctl[5];
    assign memread        = ctl[4];
    assign memwrite       = ctl[3];
    assign msize          = ctl[2:1];
    assign mem_unsigned   = ctl[0];
    assign data_ok        = dresp[64];
    assign resp_data      = dresp[63:0];
    assign unused_addr_ok = dresp[65];

    logic       mem_op, misalign;
    logic [2:0] offset;

    assign mem_op = memread | memwrite;
    assign offset = result_alu[2:0];

    always_comb begin
        misalign = 1'b0;
        case (msize)
            2'd0:    misalign = 1'b0;
            2'd1:    misalign = result_alu[0];
            2'd2:    misalign = |result_alu[1:0];
            default: misalign = |result_alu[2:0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (mem_op && !misalign) state_d = WAIT;
            WAIT: begin
                // data_ok is only honoured here, never in the cycle the request is raised
                if (data_ok) begin
                    rdata_d = resp_data;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= 64'd0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    logic        busy;
    logic [7:0]  size_mask, strobe;
    logic [63:0] wdata, shifted, load_ext, result;

    assign busy      = !reset && (((state_q == IDLE) && mem_op && !misalign) || (state_q == WAIT));
    assign stallM    = busy;
    assign misalignM = !reset && (state_q == IDLE) && mem_op && misalign;

    always_comb begin
        size_mask = 8'h01;
        case (msize)
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0f;
            default: size_mask = 8'hff;
        endcase
    end

    assign strobe  = memwrite ? (size_mask << offset) : 8'h00;
    assign wdata   = wd << {offset, 3'b000};
    assign shifted = rdata_q >> {offset, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (msize)
            2'd0:    load_ext = {{56{~mem_unsigned & shifted[7]}}, shifted[7:0]};
            2'd1:    load_ext = {{48{~mem_unsigned & shifted[15]}}, shifted[15:0]};
            2'd2:    load_ext = {{32{~mem_unsigned & shifted[31]}}, shifted[31:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        result = result_alu;
        if (misalignM) begin
            result = 64'd0;
        end else if ((state_q == DONE) && memread) begin
            result = load_ext;
        end
    end

    assign dataM    = {pc, ctl, result, wa};
    assign forwardM = {wa, result, regwrite & ~stallM};
    assign dreq     = {busy, result_alu, {1'b0, msize}, strobe, wdata};

endmodule

// File: tb/tb_memory.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for the memory stage with a byte-addressed bus device
// and an independent byte-level reference model.
module tb_memory;

    logic         clk;
    logic         reset;
    logic [202:0] dataE;
    logic [138:0] dataM;
    logic [69:0]  forwardM;
    logic         stallM, misalignM;
    logic [139:0] dreq;
    logic [65:0]  dresp;

    memory dut (
        .clk      (clk),
        .reset    (reset),
        .dataE    (dataE),
        .dataM    (dataM),
        .forwardM (forwardM),
        .stallM   (stallM),
        .misalignM(misalignM),
        .dreq     (dreq),
        .dresp    (dresp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic        dreq_valid;
    logic [63:0] dreq_addr, dreq_data;
    logic [2:0]  dreq_size;
    logic [7:0]  dreq_strobe;
    logic [63:0] dm_pc, dm_result, fwd_result;
    logic [5:0]  dm_ctl;
    logic [4:0]  dm_wa, fwd_wa;
    logic        fwd_rw;

    assign dreq_valid  = dreq[139];
    assign dreq_addr   = dreq[138:75];
    assign dreq_size   = dreq[74:72];
    assign dreq_strobe = dreq[71:64];
    assign dreq_data   = dreq[63:0];
    assign dm_pc       = dataM[138:75];
    assign dm_ctl      = dataM[74:69];
    assign dm_result   = dataM[68:5];
    assign dm_wa       = dataM[4:0];
    assign fwd_wa      = forwardM[69:65];
    assign fwd_result  = forwardM[64:1];
    assign fwd_rw      = forwardM[0];

    typedef struct {
        logic [63:0] result;
        logic        mis;
        logic [63:0] pc;
        logic [4:0]  wa;
        logic [5:0]  ctl;
        int          stall;
    } exp_t;

    typedef struct {
        logic [63:0] addr;
        logic [2:0]  size;
        logic [7:0]  strobe;
        logic [63:0] data;
        bit          is_wr;
        int          lat;
        bit          spur;
    } bus_t;

    exp_t sb_q[$];
    bus_t bus_q[$];

    logic [7:0] ref_mem [logic [63:0]];
    logic [7:0] dev_mem [logic [63:0]];

    int          vectors = 0;
    int          miscompares = 0;
    int          issued = 0;
    int          retired = 0;
    bit          slave_en = 1'b0;
    logic [63:0] pcnt = 64'h8000_0000;
    localparam logic [63:0] Base = 64'h1000_0000;

    function automatic logic [7:0] init_byte(input logic [63:0] a);
        return a[7:0] * 8'd37 + 8'd11;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [63:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
    endfunction

    function automatic logic [7:0] dev_rd(input logic [63:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_byte(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic finish_run;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic preload(input logic [63:0] a, input logic [63:0] word);
        for (int i = 0; i < 8; i++) begin
            ref_mem[a + 64'(i)] = word[8*i +: 8];
            dev_mem[a + 64'(i)] = word[8*i +: 8];
        end
    endtask

    // Reference behaviour: bytes little-endian, request must be aligned to its size.
    task automatic issue(input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] wa,
                         input bit rw, input bit rd, input bit wr, input logic [1:0] msz,
                         input bit uns, input int lat, input bit spur);
        exp_t        e;
        bus_t        b;
        int          n;
        int          off;
        bit          mis;
        logic [63:0] v;
        n   = 1 << msz;
        off = int'(addr[2:0]);
        mis = (addr & 64'(n - 1)) != 64'd0;
        e.pc  = pcnt;
        e.wa  = wa;
        e.ctl = {rw, rd, wr, msz, uns};
        e.mis = (rd | wr) & mis;
        if (e.mis) begin
            e.result = 64'd0;
            e.stall  = 0;
        end else if (rd | wr) begin
            e.stall = 1 + lat;
            b.addr  = addr;
            b.size  = {1'b0, msz};
            b.lat   = lat;
            b.spur  = spur;
            b.is_wr = wr;
            b.data  = wd << (8 * off);
            if (wr) begin
                b.strobe = 8'(((1 << n) - 1) << off);
                for (int i = 0; i < n; i++) ref_mem[addr + 64'(i)] = wd[8*i +: 8];
                e.result = addr;
            end else begin
                b.strobe = 8'h00;
                v = 64'd0;
                for (int i = 0; i < n; i++) v = v | (64'(ref_rd(addr + 64'(i))) << (8 * i));
                if (!uns && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
                e.result = v;
            end
            bus_q.push_back(b);
        end else begin
            e.result = addr;
            e.stall  = 0;
        end
        sb_q.push_back(e);
        dataE = {pcnt, addr, wd, wa, e.ctl};
        pcnt  = pcnt + 64'd4;
        issued++;
        for (int t = 0; t < 40 && retired != issued; t++) begin
            @(posedge clk);
            #1;
        end
        if (retired != issued) begin
            vectors++;
            miscompares++;
            $display("FAIL retire_timeout: got %0d retired expected %0d", retired, issued);
            finish_run();
        end
    endtask

    // Bus device: counts request cycles, optionally pulses a bogus data_ok in the first one.
    initial begin
        bus_t cur;
        int   cnt;
        logic [63:0] word;
        logic [63:0] wbase;
        cnt = 0;
        cur.lat = 1;
        cur.spur = 1'b0;
        dresp = '0;
        forever begin
            @(negedge clk);
            if (slave_en) begin
                if (reset || !dreq_valid) begin
                    cnt = 0;
                    dresp = '0;
                end else begin
                    cnt++;
                    if (cnt == 1) begin
                        if (bus_q.size() == 0) begin
                            vectors++;
                            miscompares++;
                            $display("FAIL unexpected_request: got valid addr %h expected idle bus",
                                     dreq_addr);
                            cur.lat = 1;
                            cur.spur = 1'b0;
                            cur.is_wr = 1'b0;
                            cur.addr = dreq_addr;
                            cur.size = dreq_size;
                            cur.strobe = dreq_strobe;
                            cur.data = dreq_data;
                        end else begin
                            cur = bus_q.pop_front();
                        end
                    end
                    if (cnt == 1 + cur.lat) begin
                        check("bus_addr", dreq_addr, cur.addr);
                        check("bus_size", 64'(dreq_size), 64'(cur.size));
                        check("bus_strobe", 64'(dreq_strobe), 64'(cur.strobe));
                        if (cur.is_wr) check("bus_data", dreq_data, cur.data);
                        wbase = dreq_addr & ~64'd7;
                        for (int i = 0; i < 8; i++)
                            if (dreq_strobe[i]) dev_mem[wbase + 64'(i)] = dreq_data[8*i +: 8];
                        word = 64'd0;
                        for (int i = 0; i < 8; i++)
                            word = word | (64'(dev_rd(wbase + 64'(i))) << (8 * i));
                        dresp = {1'b0, 1'b1, word};
                    end else begin
                        dresp = {1'b1, (cnt == 1) && cur.spur, {$urandom, $urandom}};
                    end
                end
            end
        end
    end

    // Monitor: an instruction retires on the first non-stalled cycle while one is outstanding.
    initial begin
        exp_t e;
        int   stall_run;
        stall_run = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stall_run = 0;
            end else if (stallM) begin
                stall_run++;
                check("stall_fwd_regwrite", 64'(fwd_rw), 64'd0);
                check("stall_valid", 64'(dreq_valid), 64'd1);
            end else if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("result", dm_result, e.result);
                check("misalign", 64'(misalignM), 64'(e.mis));
                check("fwd_result", fwd_result, e.result);
                check("fwd_regwrite", 64'(fwd_rw), 64'(e.ctl[5]));
                check("fwd_wa", 64'(fwd_wa), 64'(e.wa));
                check("pc", dm_pc, e.pc);
                check("ctl", 64'(dm_ctl), 64'(e.ctl));
                check("wa", 64'(dm_wa), 64'(e.wa));
                check("stall_cycles", 64'(stall_run), 64'(e.stall));
                check("retire_valid", 64'(dreq_valid), 64'd0);
                stall_run = 0;
                retired++;
            end
        end
    end

    initial begin
        int          kind;
        logic [1:0]  msz;
        logic [63:0] a;
        logic [63:0] d;
        reset = 1'b1;
        dataE = {64'h44, Base + 64'h8, 64'h0, 5'd3, 6'b110110};
        repeat (2) @(negedge clk);
        check("reset_valid", 64'(dreq_valid), 64'd0);
        check("reset_stall", 64'(stallM), 64'd0);
        check("reset_misalign", 64'(misalignM), 64'd0);
        check("reset_result_follows", dm_result, Base + 64'h8);
        check("reset_pc_follows", dm_pc, 64'h44);
        check("reset_fwd_regwrite", 64'(fwd_rw), 64'd1);
        reset = 1'b0;
        dataE = '0;
        slave_en = 1'b1;
        @(posedge clk);
        #1;

        // Signed byte load of 0x80 with two WAIT cycles.
        preload(Base, 64'h0000_0000_8000_0000);
        issue(Base + 64'h3, 64'h0, 5'd1, 1, 1, 0, 2'd0, 0, 2, 0);
        // Halfword store at offset 6.
        issue(Base + 64'h6, 64'hBEEF, 5'd2, 0, 0, 1, 2'd1, 0, 3, 0);
        // Misaligned word load.
        issue(Base + 64'h2, 64'h0, 5'd3, 1, 1, 0, 2'd2, 0, 1, 0);
        // Plain ALU op.
        issue(64'h1234, 64'h0, 5'd4, 1, 0, 0, 2'd0, 0, 1, 0);
        // Doubleword load with a bogus data_ok in the request cycle.
        preload(Base + 64'h8, 64'h0123_4567_89AB_CDEF);
        issue(Base + 64'h8, 64'h0, 5'd5, 1, 1, 0, 2'd3, 0, 1, 1);
        // Read back the halfword store as unsigned.
        issue(Base + 64'h6, 64'h0, 5'd6, 1, 1, 0, 2'd1, 1, 1, 0);

        for (int k = 0; k < 300; k++) begin
            kind = $urandom_range(0, 2);
            msz  = 2'($urandom_range(0, 3));
            a    = Base + 64'($urandom_range(0, 63));
            if ($urandom_range(0, 99) < 85) a = a & ~64'((1 << msz) - 1);
            d    = {$urandom, $urandom};
            case (kind)
                0: issue(a, d, 5'($urandom), 1'($urandom), 1, 0, msz, 1'($urandom),
                         $urandom_range(1, 4), $urandom_range(0, 3) == 0);
                1: issue(a, d, 5'($urandom), 1'($urandom), 0, 1, msz, 1'($urandom),
                         $urandom_range(1, 4), $urandom_range(0, 3) == 0);
                default: issue({$urandom, $urandom}, d, 5'($urandom), 1'($urandom), 0, 0, msz,
                               1'($urandom), 1, 0);
            endcase
        end

        // Reset in the middle of a WAIT, then a stray data_ok after release.
        slave_en = 1'b0;
        dresp = '0;
        dataE = {64'h99, Base, 64'h0, 5'd7, 6'b110110};
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("rst_wait_valid", 64'(dreq_valid), 64'd0);
        check("rst_wait_stall", 64'(stallM), 64'd0);
        check("rst_wait_result", dm_result, Base);
        @(negedge clk);
        dataE = {64'h9c, 64'h55, 64'h0, 5'd8, 6'b100000};
        reset = 1'b0;
        @(posedge clk);
        #1;
        dresp = {1'b1, 1'b1, 64'hDEAD_BEEF_DEAD_BEEF};
        @(posedge clk);
        #1;
        dresp = '0;
        check("post_rst_stall", 64'(stallM), 64'd0);
        check("post_rst_valid", 64'(dreq_valid), 64'd0);
        check("post_rst_rdata", dut.rdata_q, 64'd0);
        check("post_rst_result", dm_result, 64'h55);
        @(negedge clk);
        check("post_rst_stall2", 64'(stallM), 64'd0);
        finish_run();
    end

endmodule
